// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - EX/fetch-side bundle for the PC redirect unit
//
// Purpose: groups the resolved-branch inputs, the fetch handshake and the
// PC/flush/monitor outputs of pc_redirect_unit into one bundle.
// Ports (per signal):
//   br_valid_i, is_branch_taken_i, is_jump_i, target_i : resolved outcome from EX
//   if_ready_i, stall_i                                : fetch accept / hazard stall
//   pc_o, pc_valid_o                                   : fetch request
//   flush_o, misaligned_o                              : IF/ID kill, bad-target pulse
//   redirect_count_o                                   : wrapping count of redirects
// Modports: master drives the inputs (EX/fetch side), slave is the unit.
interface pc_redirect_unit_if #(
  parameter int XLEN = 32
);
  logic            br_valid_i;
  logic            is_branch_taken_i;
  logic            is_jump_i;
  logic [XLEN-1:0] target_i;
  logic            if_ready_i;
  logic            stall_i;
  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic            flush_o;
  logic            misaligned_o;
  logic [15:0]     redirect_count_o;

  modport master (
    output br_valid_i, is_branch_taken_i, is_jump_i, target_i, if_ready_i, stall_i,
    input  pc_o, pc_valid_o, flush_o, misaligned_o, redirect_count_o
  );

  modport slave (
    input  br_valid_i, is_branch_taken_i, is_jump_i, target_i, if_ready_i, stall_i,
    output pc_o, pc_valid_o, flush_o, misaligned_o, redirect_count_o
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC owner with branch redirect and IF/ID flush
//
// Purpose: holds the fetch PC, advances it by 4 on an accepted fetch, and on
// a taken branch/jump from EX loads the target and kills IF/ID for
// FLUSH_CYCLES cycles. Counts accepted redirects (wrapping, 16 bit).
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : pc_redirect_unit_if slave modport (see interface file)
// All outputs come straight from flops.
module pc_redirect_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pc_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [15:0]     redir_cnt_q, redir_cnt_d;
  logic            pc_valid_q, pc_valid_d;
  logic            flush_q, flush_d;
  logic            misaligned_q, misaligned_d;

  logic req;
  logic aligned;

  assign req     = bus.br_valid_i & (bus.is_branch_taken_i | bus.is_jump_i);
  assign aligned = (bus.target_i[1:0] == 2'b00);

  // Output flops are loaded with the value that matches the state being
  // entered, so pc_valid_o/flush_o are registered yet line up with state_q.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fcnt_d       = fcnt_q;
    redir_cnt_d  = redir_cnt_q;
    pc_valid_d   = 1'b0;
    flush_d      = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (req && aligned) begin
          // Redirect wins over stall and ignores the fetch handshake.
          state_d     = FLUSH;
          pc_d        = bus.target_i;
          fcnt_d      = FLUSH_INIT;
          redir_cnt_d = redir_cnt_q + 16'd1;
          flush_d     = 1'b1;
        end else begin
          pc_valid_d   = 1'b1;
          // A misaligned target is reported but otherwise behaves like no request.
          misaligned_d = req;
          if (bus.if_ready_i && !bus.stall_i) begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      FLUSH: begin
        // Anything EX presents here is wrong-path and is dropped.
        if (fcnt_q == 4'd0) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end else begin
          fcnt_d  = fcnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      fcnt_q       <= 4'd0;
      redir_cnt_q  <= 16'd0;
      pc_valid_q   <= 1'b0;
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fcnt_q       <= fcnt_d;
      redir_cnt_q  <= redir_cnt_d;
      pc_valid_q   <= pc_valid_d;
      flush_q      <= flush_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.pc_o             = pc_q;
  assign bus.pc_valid_o       = pc_valid_q;
  assign bus.flush_o          = flush_q;
  assign bus.misaligned_o     = misaligned_q;
  assign bus.redirect_count_o = redir_cnt_q;

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter owner for the fetch stage, sitting at the receiving end of the branch decision path. It consumes the resolved control-flow outcome from EX (branch-taken flag plus jump indication and target), redirects the PC, and kills wrong-path instructions in IF/ID for a fixed number of cycles. Otherwise it advances the PC sequentially under a fetch handshake and pipeline stall. It also keeps a wrapping count of taken redirects for performance monitoring.

## Interface
- XLEN, 32, PC/target width
- RESET_PC, 32'h0000_0000, PC value loaded at reset (bits [1:0] must be 0)
- FLUSH_CYCLES, 2, cycles of IF/ID kill after a redirect (legal 1..15)
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- br_valid_i  input  1  EX presents a resolved branch/jump this cycle
- is_branch_taken_i  input  1  branch condition satisfied (from branch decision logic)
- is_jump_i  input  1  JAL/JALR, unconditionally taken
- target_i  input  XLEN  redirect target address
- if_ready_i  input  1  fetch accepts pc_o this cycle
- stall_i  input  1  pipeline hazard stall, freezes sequential advance
- pc_o  output  XLEN  current fetch address
- pc_valid_o  output  1  pc_o is a valid fetch request
- flush_o  output  1  kill instructions in IF and ID
- misaligned_o  output  1  one-cycle pulse, redirect target not word-aligned
- redirect_count_o  output  16  number of accepted redirects, wraps

## Operation
- Redirect request: req = br_valid_i & (is_branch_taken_i | is_jump_i).
- Accepted redirect: req & target_i[1:0]==0 while in RUN.
- Misaligned request: req & target_i[1:0]!=0 in RUN → misaligned_o=1 next cycle for exactly one cycle; PC, state and counter unaffected.
- FSM states: BOOT, RUN, FLUSH.
- BOOT: pc_valid_o=0; unconditionally → RUN next cycle.
- RUN: pc_valid_o=1, flush_o=0.
  - Accepted redirect → FLUSH; pc_o<=target_i; flush counter<=FLUSH_CYCLES-1; redirect_count_o<=redirect_count_o+1 (mod 2^16).
  - Else if if_ready_i & ~stall_i → pc_o<=pc_o+4 (mod 2^XLEN).
  - Else pc_o holds.
  - Priority: redirect > stall > sequential advance; redirect ignores if_ready_i and stall_i.
- FLUSH: pc_valid_o=0, flush_o=1, pc_o holds target; counter decrements each cycle regardless of stall_i/if_ready_i; at counter==0 → RUN.
- br_valid_i in BOOT or FLUSH is ignored (wrong-path); no redirect, no misaligned pulse, no count.
- Not-taken branch (br_valid_i=1, both taken flags 0) is treated as no request.

## Timing
- Reset (rst_ni=0, immediate): state=BOOT, pc_o=RESET_PC, pc_valid_o=0, flush_o=0, misaligned_o=0, redirect_count_o=0, flush counter=0.
- First valid fetch: second rising edge after rst_ni deasserts (one BOOT cycle).
- Redirect sampled at edge N: cycles N+1..N+FLUSH_CYCLES show pc_o=target, flush_o=1, pc_valid_o=0; cycle N+FLUSH_CYCLES+1 RUN with pc_o=target, pc_valid_o=1.
- Sequential advance latency: 1 cycle after accepted handshake.
- All outputs registered; no combinational input→output path.
- Reset mid-FLUSH: flush aborted immediately, all outputs to reset values, counter preserved only by no one — returns to 0.
- PC wrap: pc_o=0xFFFF_FFFC advancing → 0x0000_0000, no flag.
- Counter wrap: 0xFFFF + accepted redirect → 0x0000.

## Test plan
- Reset/boot: release rst_ni, if_ready_i=1, stall_i=0 → one cycle pc_valid_o=0, then pc_o=0x0,0x4,0x8 on successive cycles.
- Stall/handshake: at pc_o=0x8 hold stall_i=1 for 3 cycles, then if_ready_i=0 for 2 → pc_o stays 0x8 for 5 cycles, then 0xC.
- Taken branch: at pc_o=0x10 assert br_valid_i, is_branch_taken_i, target_i=0x200 → 2 cycles flush_o=1/pc_valid_o=0, then pc_o=0x200 valid, 0x204 next; redirect_count_o=1. Same stimulus with flag 0 → pc_o=0x14, no flush.
- Jump + misaligned: is_jump_i=1, target_i=0x302 → misaligned_o pulses once, pc continues sequentially, count unchanged; target_i=0x300 → redirect, count increments.
- Ignored during flush: second taken branch (target 0x400) in first FLUSH cycle → ignored, pc_o resumes at first target, count +1 only.
- Boundaries: reset asserted in FLUSH → outputs to reset values asynchronously; pc_o=0xFFFF_FFFC advances to 0x0; 65536 redirects → redirect_count_o=0.
